mul_opnd_stage: RTL and testbench

- Registered operand-issue stage that sits directly upstream of the combinational fp multiplier datapath.
- Accepts operand pairs and a rounding mode over a valid/ready handshake and classifies each operand into one IEEE class.
- Buffers them in a 2-entry skid buffer, so in_ready is fully registered and throughput is one transaction per cycle.
- Presents registered operands, rounding mode, class vectors and a special-case hint to the multiplier.

---
 rtl/mul_pkg.sv | 51 +++++
 rtl/mul_fp_classify.sv | 40 ++++
 rtl/mul_opnd_stage.sv | 128 ++++++++++++
 tb/tb_mul_opnd_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared class indices, rounding modes and entry metadata for the fp multiplier operand stage
//
// Contents:
//   CLS_*      bit positions of the one-hot IEEE class vector
//   RND_*      rounding-mode encodings
//   entry_meta_t  per-transaction metadata kept alongside the operands
//   make_meta  builds the metadata, including the special/invalid hints
package mul_pkg;

    localparam int CLS_ZERO = 0;
    localparam int CLS_SUB  = 1;
    localparam int CLS_NORM = 2;
    localparam int CLS_INF  = 3;
    localparam int CLS_QNAN = 4;
    localparam int CLS_SNAN = 5;
    localparam int CLS_N    = 6;

    localparam logic [CLS_N-1:0] CLS_ZERO_VEC = 6'b000001;

    localparam logic [1:0] RND_RTZ = 2'b00;
    localparam logic [1:0] RND_RDN = 2'b01;
    localparam logic [1:0] RND_RUP = 2'b10;
    localparam logic [1:0] RND_RNE = 2'b11;

    typedef struct packed {
        logic [1:0]       rnd;
        logic [CLS_N-1:0] cls_a;
        logic [CLS_N-1:0] cls_b;
        logic             special;
        logic             invalid;
    } entry_meta_t;

    function automatic entry_meta_t make_meta(
        input logic [1:0]       rnd,
        input logic [CLS_N-1:0] cls_a,
        input logic [CLS_N-1:0] cls_b
    );
        entry_meta_t m;
        m.rnd     = rnd;
        m.cls_a   = cls_a;
        m.cls_b   = cls_b;
        // Any non-finite or zero operand lets the multiplier bypass the mantissa product.
        m.special = cls_a[CLS_ZERO] | cls_a[CLS_INF] | cls_a[CLS_QNAN] | cls_a[CLS_SNAN] |
                    cls_b[CLS_ZERO] | cls_b[CLS_INF] | cls_b[CLS_QNAN] | cls_b[CLS_SNAN];
        m.invalid = cls_a[CLS_SNAN] | cls_b[CLS_SNAN] |
                    (cls_a[CLS_ZERO] & cls_b[CLS_INF]) |
                    (cls_a[CLS_INF]  & cls_b[CLS_ZERO]);
        return m;
    endfunction

endpackage

// File: rtl/mul_fp_classify.sv
// rtl/mul_fp_classify.sv - combinational one-hot IEEE class of one operand
//
// Ports:
//   expo  in   exponent field
//   mant  in   stored mantissa field
//   cls   out  one-hot class (zero, sub, norm, inf, qnan, snan)
module mul_fp_classify
    import mul_pkg::*;
#(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic [EXPO_W-1:0] expo,
    input  logic [MANT_W-1:0] mant,
    output logic [CLS_N-1:0]  cls
);

    logic expo_zero;
    logic expo_ones;
    logic mant_zero;

    always_comb begin
        expo_zero = (expo == '0);
        expo_ones = &expo;
        mant_zero = (mant == '0);
        cls       = '0;
        if (expo_zero) begin
            if (mant_zero) cls[CLS_ZERO] = 1'b1;
            else           cls[CLS_SUB]  = 1'b1;
        end else if (expo_ones) begin
            // Mantissa MSB is the quiet bit; a clear quiet bit with a nonzero payload is signalling.
            if (mant_zero)              cls[CLS_INF]  = 1'b1;
            else if (mant[MANT_W-1])    cls[CLS_QNAN] = 1'b1;
            else                        cls[CLS_SNAN] = 1'b1;
        end else begin
            cls[CLS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_opnd_stage.sv
// rtl/mul_opnd_stage.sv - registered operand-issue stage with 2-entry skid buffer ahead of the fp multiplier
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous discard of both entries; input in the same cycle is dropped
//   in_valid/in_ready   upstream handshake; in_ready is a flop output
//   in_a, in_b, in_rnd  operands and rounding mode
//   out_valid/out_ready downstream handshake
//   out_a, out_b, out_rnd  registered operands and rounding mode
//   out_cls_a, out_cls_b   one-hot operand classes captured with the operands
//   out_special, out_invalid  special-case hints captured with the operands
module mul_opnd_stage
    import mul_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] in_a,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0] in_b,
    input  logic [1:0]                      in_rnd,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] out_a,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] out_b,
    output logic [1:0]                      out_rnd,
    output logic [CLS_N-1:0]                out_cls_a,
    output logic [CLS_N-1:0]                out_cls_b,
    output logic                            out_special,
    output logic                            out_invalid
);

    localparam int W = SIGN_W + EXPO_W + MANT_W;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        entry_meta_t  meta;
    } entry_t;

    logic [CLS_N-1:0] cls_a;
    logic [CLS_N-1:0] cls_b;
    entry_t           in_entry;

    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;

    logic accept;
    logic consume;

    mul_fp_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_a (
        .expo (in_a[MANT_W +: EXPO_W]),
        .mant (in_a[MANT_W-1:0]),
        .cls  (cls_a)
    );

    mul_fp_classify #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_cls_b (
        .expo (in_b[MANT_W +: EXPO_W]),
        .mant (in_b[MANT_W-1:0]),
        .cls  (cls_b)
    );

    always_comb begin
        in_entry      = '0;
        in_entry.a    = in_a;
        in_entry.b    = in_b;
        in_entry.meta = make_meta(in_rnd, cls_a, cls_b);
    end

    // The skid entry is the only thing that can block input, so readiness is just its emptiness.
    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign consume  = main_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid         <= 1'b0;
            skid_valid         <= 1'b0;
            main_q             <= '0;
            main_q.meta.cls_a  <= CLS_ZERO_VEC;
            main_q.meta.cls_b  <= CLS_ZERO_VEC;
            skid_q             <= '0;
            skid_q.meta.cls_a  <= CLS_ZERO_VEC;
            skid_q.meta.cls_b  <= CLS_ZERO_VEC;
        end else if (flush) begin
            // Any consume this cycle already completed on the wire; only the state is dropped.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                // in_ready was low, so no accept can coincide with this refill.
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = main_valid;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_rnd     = main_q.meta.rnd;
    assign out_cls_a   = main_q.meta.cls_a;
    assign out_cls_b   = main_q.meta.cls_b;
    assign out_special = main_q.meta.special;
    assign out_invalid = main_q.meta.invalid;

endmodule

// File: tb/tb_mul_opnd_stage.sv
// tb/tb_mul_opnd_stage.sv - directed self-checking bench for mul_opnd_stage
module tb_mul_opnd_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [1:0]  out_rnd;
    logic [5:0]  out_cls_a;
    logic [5:0]  out_cls_b;
    logic        out_special;
    logic        out_invalid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_opnd_stage #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rnd      (in_rnd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rnd     (out_rnd),
        .out_cls_a   (out_cls_a),
        .out_cls_b   (out_cls_b),
        .out_special (out_special),
        .out_invalid (out_invalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One active edge, then settle on the falling edge where checks and new drives happen.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] r);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_rnd   = r;
    endtask

    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] r, input logic [5:0] ca, input logic [5:0] cb,
                             input logic sp, input logic inv);
        check({tag, ".valid"},   {31'd0, out_valid},   32'd1);
        check({tag, ".a"},       out_a,                a);
        check({tag, ".b"},       out_b,                b);
        check({tag, ".rnd"},     {30'd0, out_rnd},     {30'd0, r});
        check({tag, ".cls_a"},   {26'd0, out_cls_a},   {26'd0, ca});
        check({tag, ".cls_b"},   {26'd0, out_cls_b},   {26'd0, cb});
        check({tag, ".special"}, {31'd0, out_special}, {31'd0, sp});
        check({tag, ".invalid"}, {31'd0, out_invalid}, {31'd0, inv});
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.out_a",     out_a,              32'd0);
        check("rst.out_b",     out_b,              32'd0);
        check("rst.cls_a",     {26'd0, out_cls_a}, 32'h01);
        check("rst.cls_b",     {26'd0, out_cls_b}, 32'h01);
        check("rst.special",   {31'd0, out_special}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Classification vectors, streamed one per cycle with out_ready high.
        out_ready = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h40000000, 2'b11);
        step();
        check_out("norm", 32'h3F800000, 32'h40000000, 2'b11, 6'b000100, 6'b000100, 1'b0, 1'b0);
        drive(1'b1, 32'h00000000, 32'h7F800000, 2'b00);
        step();
        check_out("zero_inf", 32'h00000000, 32'h7F800000, 2'b00, 6'b000001, 6'b001000, 1'b1, 1'b1);
        drive(1'b1, 32'h7F800001, 32'h00000001, 2'b01);
        step();
        check_out("snan_sub", 32'h7F800001, 32'h00000001, 2'b01, 6'b100000, 6'b000010, 1'b1, 1'b1);
        drive(1'b1, 32'h7FC00000, 32'h80000000, 2'b10);
        step();
        check_out("qnan_nzero", 32'h7FC00000, 32'h80000000, 2'b10, 6'b010000, 6'b000001, 1'b1, 1'b0);
        drive(1'b1, 32'hFF800000, 32'h3F800000, 2'b11);
        step();
        check_out("ninf_norm", 32'hFF800000, 32'h3F800000, 2'b11, 6'b001000, 6'b000100, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        check("idle.out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two entries captured, then in_ready drops and the head holds.
        out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 2'b00);
        step();
        check("bp0.out_a",    out_a,             32'h3F800000);
        check("bp0.in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h40000000, 32'h40000000, 2'b01);
        step();
        check("bp1.in_ready", {31'd0, in_ready}, 32'd0);
        check("bp1.out_a",    out_a,             32'h3F800000);
        drive(1'b1, 32'h40400000, 32'h40400000, 2'b10);
        step();
        check("bp2.in_ready", {31'd0, in_ready}, 32'd0);
        check("bp2.out_a",    out_a,             32'h3F800000);
        check("bp2.out_rnd",  {30'd0, out_rnd},  32'd0);
        out_ready = 1'b1;
        step();
        check("drain0.out_a",    out_a,             32'h40000000);
        check("drain0.out_rnd",  {30'd0, out_rnd},  32'd1);
        check("drain0.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("drain1.out_a",     out_a,              32'h40400000);
        check("drain1.out_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 32'h40800000, 32'h40800000, 2'b11);
        step();
        check("drain2.out_a",     out_a,              32'h40800000);
        check("drain2.out_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        check("drain3.out_valid", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full and a new input offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h41000000, 32'h41000000, 2'b00);
        step();
        drive(1'b1, 32'h41100000, 32'h41100000, 2'b00);
        step();
        check("fl.pre_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h41200000, 32'h41200000, 2'b00);
        step();
        flush = 1'b0;
        check("fl.out_valid", {31'd0, out_valid}, 32'd0);
        check("fl.in_ready",  {31'd0, in_ready},  32'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        out_ready = 1'b1;
        step();
        check("fl.after_valid", {31'd0, out_valid}, 32'd0);

        // Flush with in_ready high still drops the offered input.
        out_ready = 1'b0;
        drive(1'b1, 32'h41300000, 32'h41300000, 2'b00);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h41400000, 32'h41400000, 2'b00);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        check("fl2.out_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("fl2.after_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-transaction.
        drive(1'b1, 32'h41500000, 32'h41500000, 2'b10);
        step();
        drive(1'b1, 32'h41600000, 32'h41600000, 2'b10);
        step();
        check("ar.pre_valid",    {31'd0, out_valid}, 32'd1);
        check("ar.pre_in_ready", {31'd0, in_ready},  32'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #1 rst = 1'b1;
        #1;
        check("ar.out_valid", {31'd0, out_valid}, 32'd0);
        check("ar.in_ready",  {31'd0, in_ready},  32'd1);
        check("ar.out_a",     out_a,              32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hC0490FDB, 32'h00400000, 2'b11);
        step();
        check_out("post_rst", 32'hC0490FDB, 32'h00400000, 2'b11, 6'b000100, 6'b000010, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        check("post_rst.idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
